// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 encodings, field widths and FSM state types for the
// SRAM responder and its address helper.
package axi_pkg;

   localparam int AXI_ID_W  = 4;
   localparam int AXI_LEN_W = 8;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {R_IDLE, R_DATA, R_NEXT} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

   // The encodings order by severity, so the worse response is the larger code
   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: combinational per-beat address step, SRAM word index and
// response classification for one AXI burst engine.
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 4096
) (
   input  logic [31:0]                    addr,
   input  logic [2:0]                     size,
   input  logic [1:0]                     burst,
   output logic [31:0]                    next_addr,
   output logic [$clog2(DEPTH_WORDS)-1:0] word_idx,
   output logic [1:0]                     resp
);
   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

   logic [31:0] offset;

   // Offset wraps modulo 2^32, so addresses below the base land far above SPAN
   assign offset    = addr - BASE_ADDR;
   assign word_idx  = offset[IDX_W+1:2];
   assign next_addr = (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;

   // Unmapped addresses decode-error first; WRAP/reserved bursts and wide beats are slave errors
   always_comb begin
      resp = RESP_OKAY;
      if ({1'b0, offset} >= SPAN)
         resp = RESP_DECERR;
      else if (burst[1] || size > 3'd2)
         resp = RESP_SLVERR;
   end

endmodule

// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI4 subordinate backed by a word-addressed SRAM.
// Independent read and write engines, INCR/FIXED bursts, IDs echoed.
// Build option AXI_SRAM_RAND_DELAY_EN inserts LFSR-driven 0-3 cycle waits
// before arready, awready, each rvalid beat and bvalid.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high, current beat held until rready
// R_NEXT | one-cycle gap while the next beat is fetched
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, writing beats until wlast
// W_RESP | bvalid high with the worst response of the burst
module axi_sram_responder
   import axi_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 arvalid,
   output logic                 arready,
   input  logic [31:0]          araddr,
   input  logic [AXI_ID_W-1:0]  arid,
   input  logic [AXI_LEN_W-1:0] arlen,
   input  logic [2:0]           arsize,
   input  logic [1:0]           arburst,
   output logic                 rvalid,
   input  logic                 rready,
   output logic [31:0]          rdata,
   output logic [1:0]           rresp,
   output logic [AXI_ID_W-1:0]  rid,
   output logic                 rlast,
   input  logic                 awvalid,
   output logic                 awready,
   input  logic [31:0]          awaddr,
   input  logic [AXI_ID_W-1:0]  awid,
   input  logic [AXI_LEN_W-1:0] awlen,
   input  logic [2:0]           awsize,
   input  logic [1:0]           awburst,
   input  logic                 wvalid,
   output logic                 wready,
   input  logic [31:0]          wdata,
   input  logic [3:0]           wstrb,
   input  logic                 wlast,
   output logic                 bvalid,
   input  logic                 bready,
   output logic [1:0]           bresp,
   output logic [AXI_ID_W-1:0]  bid
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [31:0] mem [DEPTH_WORDS];

   r_state_e             r_state, r_state_nxt;
   logic [31:0]          r_addr, r_data, rd_addr, rd_next;
   logic [AXI_ID_W-1:0]  r_id;
   logic [AXI_LEN_W-1:0] r_len, r_beat;
   logic [2:0]           r_size, rd_size;
   logic [1:0]           r_burst, rd_burst, r_resp, rd_resp;
   logic [IDX_W-1:0]     rd_idx;
   logic                 ar_fire, r_fire, r_last_beat, r_go;

   w_state_e             w_state, w_state_nxt;
   logic [31:0]          w_addr, wr_next;
   logic [AXI_ID_W-1:0]  w_id;
   logic [AXI_LEN_W-1:0] w_len, w_beat;
   logic [2:0]           w_size;
   logic [1:0]           w_burst, wr_resp, w_err, w_err_nxt;
   logic [IDX_W-1:0]     wr_idx;
   logic                 aw_fire, w_fire, b_fire, w_over, w_we, w_go;

`ifdef AXI_SRAM_RAND_DELAY_EN
   logic [7:0] lfsr;
   logic [1:0] r_dly, w_dly;

   // Free-running Fibonacci LFSR, taps 8,6,5,4
   always_ff @(posedge clock) begin
      if (reset) lfsr <= LFSR_SEED;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   // Wait counters reload on every state entry and count down to zero
   always_ff @(posedge clock) begin
      if (reset) begin
         r_dly <= 2'd0;
         w_dly <= 2'd0;
      end else begin
         if (r_state_nxt != r_state) r_dly <= lfsr[1:0];
         else if (r_dly != 2'd0)     r_dly <= r_dly - 2'd1;
         if (w_state_nxt != w_state) w_dly <= lfsr[1:0];
         else if (w_dly != 2'd0)     w_dly <= w_dly - 2'd1;
      end
   end

   assign r_go = (r_dly == 2'd0);
   assign w_go = (w_dly == 2'd0);
`else
   // The seed only matters with the delay LFSR; both terms fold to 1
   assign r_go = (LFSR_SEED != 8'h00);
   assign w_go = (LFSR_SEED != 8'h00);
`endif

   // ---------------- read engine ----------------
   assign rd_addr  = (r_state == R_IDLE) ? araddr  : r_addr;
   assign rd_size  = (r_state == R_IDLE) ? arsize  : r_size;
   assign rd_burst = (r_state == R_IDLE) ? arburst : r_burst;

   axi_burst_addr #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS)) u_rd_addr (
      .addr(rd_addr), .size(rd_size), .burst(rd_burst),
      .next_addr(rd_next), .word_idx(rd_idx), .resp(rd_resp)
   );

   assign arready     = !reset && (r_state == R_IDLE) && r_go;
   assign rvalid      = !reset && (r_state == R_DATA) && r_go;
   assign ar_fire     = arvalid && arready;
   assign r_fire      = rvalid && rready;
   assign r_last_beat = (r_beat == r_len);
   assign rlast       = rvalid && r_last_beat;
   assign rdata       = reset ? 32'd0 : r_data;
   assign rresp       = reset ? 2'd0 : r_resp;
   assign rid         = reset ? '0 : r_id;

   // Read state register
   always_ff @(posedge clock) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= r_state_nxt;
   end

   // Read next-state: one gap cycle between beats while the next word is fetched
   always_comb begin
      r_state_nxt = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_fire) r_state_nxt = R_DATA;
         R_DATA:  if (r_fire)  r_state_nxt = r_last_beat ? R_IDLE : R_NEXT;
         R_NEXT:  r_state_nxt = R_DATA;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read datapath: fetch on AR accept and in the gap; the array read sees pre-write data
   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr <= '0; r_id <= '0; r_len <= '0; r_size <= '0; r_burst <= '0;
         r_beat <= '0; r_data <= '0; r_resp <= RESP_OKAY;
      end else begin
         if (ar_fire) begin
            r_addr  <= araddr;
            r_id    <= arid;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_beat  <= '0;
         end
         if (r_fire && !r_last_beat) begin
            r_addr <= rd_next;
            r_beat <= r_beat + 8'd1;
         end
         if (ar_fire || r_state == R_NEXT) begin
            r_data <= (rd_resp == RESP_OKAY) ? mem[rd_idx] : 32'd0;
            r_resp <= rd_resp;
         end
      end
   end

   // ---------------- write engine ----------------
   axi_burst_addr #(.BASE_ADDR(BASE_ADDR), .DEPTH_WORDS(DEPTH_WORDS)) u_wr_addr (
      .addr(w_addr), .size(w_size), .burst(w_burst),
      .next_addr(wr_next), .word_idx(wr_idx), .resp(wr_resp)
   );

   assign awready = !reset && (w_state == W_IDLE) && w_go;
   assign wready  = !reset && (w_state == W_DATA);
   assign bvalid  = !reset && (w_state == W_RESP) && w_go;
   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;
   assign b_fire  = bvalid && bready;
   assign bresp   = reset ? 2'd0 : w_err;
   assign bid     = reset ? '0 : w_id;

   // Per-beat response merge and write enable; beats past len are swallowed
   always_comb begin
      w_err_nxt = resp_max(w_err, wr_resp);
      if (w_over || (wlast && w_beat != w_len))
         w_err_nxt = resp_max(w_err_nxt, RESP_SLVERR);
      w_we = w_fire && !w_over && (wr_resp == RESP_OKAY);
   end

   // Write state register
   always_ff @(posedge clock) begin
      if (reset) w_state <= W_IDLE;
      else       w_state <= w_state_nxt;
   end

   // Write next-state: wlast ends the burst regardless of the beat count
   always_comb begin
      w_state_nxt = w_state;
      unique case (w_state)
         W_IDLE:  if (aw_fire)          w_state_nxt = W_DATA;
         W_DATA:  if (w_fire && wlast)  w_state_nxt = W_RESP;
         W_RESP:  if (b_fire)           w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Write datapath: latch AW fields, step address and accumulate the worst response
   always_ff @(posedge clock) begin
      if (reset) begin
         w_addr <= '0; w_id <= '0; w_len <= '0; w_size <= '0; w_burst <= '0;
         w_beat <= '0; w_over <= 1'b0; w_err <= RESP_OKAY;
      end else begin
         if (aw_fire) begin
            w_addr  <= awaddr;
            w_id    <= awid;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_beat  <= '0;
            w_over  <= 1'b0;
            w_err   <= RESP_OKAY;
         end
         if (w_fire) begin
            w_addr <= wr_next;
            w_beat <= w_beat + 8'd1;
            w_err  <= w_err_nxt;
            if (w_beat == w_len && !wlast) w_over <= 1'b1;
         end
      end
   end

   // SRAM byte-lane writes; contents survive reset
   always_ff @(posedge clock) begin
      if (w_we) begin
         for (int i = 0; i < 4; i++)
            if (wstrb[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: directed vectors with hand-computed expectations
// for the default (no random delay) build of axi_sram_responder.
module tb_axi_sram_responder;
   logic        clock = 1'b0;
   logic        reset;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] araddr, rdata;
   logic [3:0]  arid, rid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, rresp;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [31:0] awaddr, wdata;
   logic [3:0]  awid, wstrb, bid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst, bresp;

   axi_sram_responder dut (
      .clock(clock), .reset(reset),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rid(rid), .rlast(rlast),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_pass = 0;

   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic        wl [16];
   logic [31:0] rd [16];
   logic [1:0]  rr [16];
   logic        rl [16];
   logic [3:0]  rid_seen;
   logic        first_rv, stab_ok;
   int          nb;
   logic [1:0]  b_resp;
   logic [3:0]  b_id;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Called at a negedge; AW, then wd/ws/wl beats, then B. Returns at a negedge.
   task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] bu, input int nbeats,
                           output logic [1:0] resp, output logic [3:0] rbid);
      int n;
      awaddr = a; awid = id; awlen = len; awsize = 3'd2; awburst = bu; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 20) begin @(negedge clock); n++; end
      if (n >= 20) chk("aw_timeout", 32'd0, 32'd1);
      @(negedge clock);
      awvalid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
         n = 0;
         while (!wready && n < 20) begin @(negedge clock); n++; end
         if (n >= 20) chk("w_timeout", 32'd0, 32'd1);
         @(negedge clock);
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      n = 0;
      while (!bvalid && n < 20) begin @(negedge clock); n++; end
      if (n >= 20) chk("b_timeout", 32'd0, 32'd1);
      resp = bresp; rbid = bid;
      @(negedge clock);
      bready = 1'b0;
   endtask

   // Called at a negedge; collects beats into rd/rr/rl. Beat stall_at is held off 5 cycles.
   task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu, input int stall_at);
      int n;
      logic [38:0] hold;
      logic stalled;
      araddr = a; arid = id; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin @(negedge clock); n++; end
      if (n >= 20) chk("ar_timeout", 32'd0, 32'd1);
      @(negedge clock);
      arvalid = 1'b0;
      first_rv = rvalid;
      nb = 0; stab_ok = 1'b1; stalled = 1'b0; rready = 1'b1; n = 0;
      while (n < 300) begin
         if (rvalid) begin
            if (nb == stall_at && !stalled) begin
               rready = 1'b0; stalled = 1'b1;
               hold = {rdata, rresp, rlast, rid};
               repeat (5) begin
                  @(negedge clock);
                  if (!rvalid || {rdata, rresp, rlast, rid} != hold) stab_ok = 1'b0;
               end
               rready = 1'b1;
            end
            if (nb < 16) begin rd[nb] = rdata; rr[nb] = rresp; rl[nb] = rlast; end
            rid_seen = rid;
            nb++;
            if (rlast) break;
         end
         @(negedge clock);
         n++;
      end
      if (n >= 300) chk("r_timeout", 32'd0, 32'd1);
      @(negedge clock);
      rready = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
      awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
      repeat (2) @(negedge clock);
      chk("rst_ready", {arready, awready, wready}, 3'b000);
      chk("rst_valid", {rvalid, bvalid}, 2'b00);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ids", {rid, bid, rresp, bresp, rlast}, 13'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle_ready", {arready, awready, wready}, 3'b110);

      // single write then read
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
      do_write(32'h8000_0010, 4'd5, 8'd0, 2'b01, 1, b_resp, b_id);
      chk("wr1_bresp", b_resp, 2'b00);
      chk("wr1_bid", b_id, 4'd5);
      do_read(32'h8000_0010, 4'd3, 8'd0, 3'd2, 2'b01, -1);
      chk("rd1_latency", first_rv, 1'b1);
      chk("rd1_beats", nb, 1);
      chk("rd1_data", rd[0], 32'hDEADBEEF);
      chk("rd1_rid", rid_seen, 4'd3);
      chk("rd1_rlast", rl[0], 1'b1);
      chk("rd1_rresp", rr[0], 2'b00);

      // burst with partial strobes on beat 2 over a known old word
      wd[0] = 32'hCAFEF00D; ws[0] = 4'hF; wl[0] = 1'b1;
      do_write(32'h8000_0108, 4'd1, 8'd0, 2'b01, 1, b_resp, b_id);
      wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
      ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'b0011; ws[3] = 4'hF;
      wl[0] = 0; wl[1] = 0; wl[2] = 0; wl[3] = 1;
      do_write(32'h8000_0100, 4'd1, 8'd3, 2'b01, 4, b_resp, b_id);
      chk("burst_bresp", b_resp, 2'b00);
      do_read(32'h8000_0100, 4'd2, 8'd3, 3'd2, 2'b01, 1);
      chk("burst_beats", nb, 4);
      chk("burst_d0", rd[0], 32'd1);
      chk("burst_d1", rd[1], 32'd2);
      chk("burst_d2_strb", rd[2], 32'hCAFE0003);
      chk("burst_d3", rd[3], 32'd4);
      chk("burst_rlast", {rl[3], rl[2], rl[1], rl[0]}, 4'b1000);
      chk("stall_stable", stab_ok, 1'b1);

      // error responses
      do_read(32'h7FFF_FFFC, 4'd4, 8'd0, 3'd2, 2'b01, -1);
      chk("decerr_resp", rr[0], 2'b11);
      chk("decerr_data", rd[0], 32'd0);
      do_read(32'h8000_0010, 4'd6, 8'd2, 3'd2, 2'b10, -1);
      chk("wrap_beats", nb, 3);
      chk("wrap_resp", {rr[2], rr[1], rr[0]}, 6'b101010);
      chk("wrap_data", rd[0] | rd[1] | rd[2], 32'd0);
      do_read(32'h8000_0010, 4'd6, 8'd0, 3'd3, 2'b01, -1);
      chk("size3_resp", rr[0], 2'b10);
      wd[0] = 32'h0A; wd[1] = 32'h0B; ws[0] = 4'hF; ws[1] = 4'hF; wl[0] = 0; wl[1] = 1;
      do_write(32'h8000_0200, 4'd2, 8'd3, 2'b01, 2, b_resp, b_id);
      chk("early_wlast_bresp", b_resp, 2'b10);
      chk("early_wlast_bid", b_id, 4'd2);

      // extra beat past len is accepted but not written
      wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF; wl[0] = 1'b1;
      do_write(32'h8000_0304, 4'd9, 8'd0, 2'b01, 1, b_resp, b_id);
      wd[0] = 32'h11111111; wd[1] = 32'h22222222; ws[0] = 4'hF; ws[1] = 4'hF; wl[0] = 0; wl[1] = 1;
      do_write(32'h8000_0300, 4'd9, 8'd0, 2'b01, 2, b_resp, b_id);
      chk("overrun_bresp", b_resp, 2'b10);
      do_read(32'h8000_0300, 4'd1, 8'd1, 3'd2, 2'b01, -1);
      chk("overrun_d0", rd[0], 32'h11111111);
      chk("overrun_d1_kept", rd[1], 32'h5A5A5A5A);

      wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF; wl[0] = 1'b1;
      do_write(32'h9000_0000, 4'd1, 8'd0, 2'b01, 1, b_resp, b_id);
      chk("wr_decerr", b_resp, 2'b11);

      // FIXED bursts stay on one word
      wd[0] = 32'hA; wd[1] = 32'hB; ws[0] = 4'hF; ws[1] = 4'hF; wl[0] = 0; wl[1] = 1;
      do_write(32'h8000_0400, 4'd8, 8'd1, 2'b00, 2, b_resp, b_id);
      do_read(32'h8000_0400, 4'd8, 8'd1, 3'd2, 2'b00, -1);
      chk("fixed_beats", nb, 2);
      chk("fixed_data", {rd[0], rd[1]}, {32'hB, 32'hB});

      // same-cycle read and write of one word: read sees the old value
      awaddr = 32'h8000_0010; awid = 4'hC; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 1;
      n = 0;
      while (!awready && n < 20) begin @(negedge clock); n++; end
      @(negedge clock);
      awvalid = 0;
      wdata = 32'h12345678; wstrb = 4'hF; wlast = 1; wvalid = 1;
      araddr = 32'h8000_0010; arid = 4'd7; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 1;
      chk("cc_both_ready", {wready, arready}, 2'b11);
      @(negedge clock);
      wvalid = 0; wlast = 0; arvalid = 0;
      chk("cc_rvalid_bvalid", {rvalid, bvalid}, 2'b11);
      chk("cc_old_data", rdata, 32'hDEADBEEF);
      rready = 1; bready = 1;
      @(negedge clock);
      rready = 0; bready = 0;

      // reset during beat 2 of an 8-beat read
      araddr = 32'h8000_0100; arid = 4'd5; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1;
      n = 0;
      while (!arready && n < 20) begin @(negedge clock); n++; end
      @(negedge clock);
      arvalid = 0; rready = 1; nb = 0; n = 0;
      while (nb < 2 && n < 50) begin
         if (rvalid) nb++;
         @(negedge clock);
         n++;
      end
      rready = 0;
      while (!rvalid && n < 50) begin @(negedge clock); n++; end
      chk("mid_beat2_rvalid", rvalid, 1'b1);
      reset = 1;
      @(negedge clock);
      chk("mid_rst_outputs", {rvalid, rlast, arready}, 3'b000);
      reset = 0;
      @(negedge clock);
      chk("mid_rst_idle", {rvalid, arready}, 2'b01);
      do_read(32'h8000_0100, 4'd1, 8'd0, 3'd2, 2'b01, -1);
      chk("mem_kept_100", rd[0], 32'd1);
      do_read(32'h8000_0010, 4'd1, 8'd0, 3'd2, 2'b01, -1);
      chk("cc_new_data", rd[0], 32'h12345678);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI4 subordinate (responder) backed by an on-chip word-addressed SRAM array; the memory-side end of the single-port bus produced by the IFU/LSU arbiter.
- Independent read and write engines; INCR/FIXED bursts, 4-bit IDs echoed, OKAY/SLVERR/DECERR responses.
- Used as the NPC simulation memory and as the reference target for arbiter/cache verification.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the array; power of two.
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0.
- LFSR_SEED, 8'hA5, nonzero seed for the optional delay LFSR.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- arvalid in 1; arready out 1; araddr in 32; arid in 4; arlen in 8; arsize in 3; arburst in 2  (read address)
- rvalid out 1; rready in 1; rdata out 32; rresp out 2; rid out 4; rlast out 1  (read data)
- awvalid in 1; awready out 1; awaddr in 32; awid in 4; awlen in 8; awsize in 3; awburst in 2  (write address)
- wvalid in 1; wready out 1; wdata in 32; wstrb in 4; wlast in 1  (write data)
- bvalid out 1; bready in 1; bresp out 2; bid out 4  (write response)

Behaviour:
- Reset: all valid and ready outputs are 0 while reset is high. rdata, rresp, rid, rlast, bresp, bid are 0. Both FSMs go to IDLE. SRAM contents are not cleared. Reset mid-burst abandons the burst with no further beats.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&&arready, latch addr, id, len, size, burst; beat counter=0; go to R_DATA.
  - R_DATA: rvalid=1 starting the cycle after the AR handshake. rdata/rresp are registered and held stable while rvalid&&!rready. rlast=(beat==len).
  - On r fire: if rlast, return to R_IDLE. Otherwise advance addr, beat++, and present the next beat on the next cycle; there is a 1-cycle gap between beats.
- Write FSM:
  - W_IDLE: awready=1. On aw fire, latch fields; go to W_DATA.
  - W_DATA: wready=1. Each w fire writes the enabled bytes (wstrb[i] writes byte i) at the current addr, then advances addr. On w fire with wlast, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=worst response over the burst (DECERR > SLVERR > OKAY). On b fire, return to W_IDLE.
- Address advance:
  - INCR(01): addr += (1<<size).
  - FIXED(00): addr unchanged.
  - WRAP(10) and reserved(11): every beat gets SLVERR, rdata=0, and no write.
  - size>2: SLVERR on every beat.
  - Word index = (addr-BASE_ADDR)>>2. Addresses outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) return DECERR, rdata=0, and the write is dropped.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
- wlast mismatch:
  - wlast before beat len: burst terminates and bresp=SLVERR.
  - Beat count exceeding len without wlast: extra beats are accepted, not written, and bresp=SLVERR.
- Concurrency: read and write engines run simultaneously. A read and a write to the same word in the same cycle: the read returns pre-write data.
- Handshake: a valid, once asserted, stays asserted until its handshake completes, and the payload does not change meanwhile.

Optional Feature:
- AXI_SRAM_RAND_DELAY_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seeded LFSR_SEED, reset to seed) inserts 0-3 wait cycles (lfsr[1:0]) before asserting arready, awready, each rvalid beat, and bvalid.
  - A delay counter loads on entry to each wait point.
  - The LFSR advances every cycle.
- Undefined: no LFSR. Timing is exactly as in Behaviour.

Decomposition:
- Package axi_pkg holds:
  - burst codes BURST_FIXED/INCR/WRAP;
  - response codes RESP_OKAY=00, RESP_SLVERR=10, RESP_DECERR=11;
  - field widths AXI_ID_W=4, AXI_LEN_W=8;
  - read and write FSM state enums.
- One sub-module, axi_burst_addr: combinational next-address and response classification (addr, size, burst, BASE_ADDR, DEPTH_WORDS → next_addr, word_idx, resp). Instantiated twice, once for read and once for write.

Test Plan:
- Single write then read:
  - Write: AW 0x8000_0010, len=0, size=2, INCR; W 0xDEADBEEF, wstrb=1111 → bresp=00, bid=awid.
  - Read: AR same address, id=3 → one beat, rdata=0xDEADBEEF, rid=3, rlast=1, rvalid 1 cycle after AR.
- Burst with partial strobes:
  - INCR len=3 write from 0x8000_0100 with data 1,2,3,4; beat 2 uses wstrb=0011 → word 0x108 low half updated only.
  - Read back the same burst → four beats, rlast on beat 3 only.
- Backpressure: rready held low for 5 cycles mid-burst → rvalid, rdata, rlast stable throughout; no beat lost or duplicated.
- Error responses:
  - Read 0x7FFF_FFFC → DECERR, rdata=0.
  - arburst=10 → SLVERR for all len+1 beats.
  - Write with wlast on beat 1 of len=3 → bresp=10.
- Concurrency and reset:
  - Read and write to the same word in the same cycle → read returns old value.
  - Reset asserted during beat 2 of an 8-beat read → rvalid=0 next cycle, FSM idle, memory preserved.
- AXI_SRAM_RAND_DELAY_EN: 1000 random transactions against a scoreboard → data and IDs match, and observed wait cycles are ≤3 at every wait point.
